// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life generation engine: board defaults,
// FSM encoding and the B3/S23 rule constants.
package life_pkg;

    localparam int X_DEF  = 8;
    localparam int Y_DEF  = 8;
    localparam int GW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SCAN,
        COMMIT,
        DONE
    } state_t;

    // B3/S23: birth on exactly 3 neighbours, survival on 2 (3 is covered by birth)
    localparam logic [3:0] BIRTH_N   = 4'd3;
    localparam logic [3:0] SURVIVE_N = 4'd2;

endpackage

// File: rtl/life_cell_rule.sv
// One-cell Life rule: masks neighbours at the board edges (unless wrapping),
// counts the live ones and applies B3/S23.
module life_cell_rule
    import life_pkg::*;
#(
    parameter int X  = X_DEF,
    parameter int Y  = Y_DEF,
    parameter int XW = $clog2(X),
    parameter int YW = $clog2(Y)
) (
    input  logic          c,
    input  logic          l,
    input  logic          r,
    input  logic          u,
    input  logic          d,
    input  logic          lu,
    input  logic          ru,
    input  logic          ld,
    input  logic          rd,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          wrap,
    output logic          alive
);

    logic       at_l, at_r, at_u, at_d;
    logic [7:0] nb;
    logic [3:0] n;

    assign at_l = !wrap && (x == '0);
    assign at_r = !wrap && (x == XW'(X - 1));
    assign at_u = !wrap && (y == '0);
    assign at_d = !wrap && (y == YW'(Y - 1));

    assign nb[0] = l  & ~at_l;
    assign nb[1] = r  & ~at_r;
    assign nb[2] = u  & ~at_u;
    assign nb[3] = d  & ~at_d;
    assign nb[4] = lu & ~at_l & ~at_u;
    assign nb[5] = ru & ~at_r & ~at_u;
    assign nb[6] = ld & ~at_l & ~at_d;
    assign nb[7] = rd & ~at_r & ~at_d;

    always_comb begin
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nb[i]};
        end
    end

    assign alive = (n == BIRTH_N) | (c & (n == SURVIVE_N));

endmodule

// File: rtl/life_gen_engine.sv
// Serial Game-of-Life engine: rotates a copy of the board past fixed taps,
// evaluating one cell per cycle, and commits a whole generation at once.
module life_gen_engine
    import life_pkg::*;
#(
    parameter int X  = X_DEF,
    parameter int Y  = Y_DEF,
    parameter int GW = GW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    input  logic [X*Y-1:0] load_data,
    output logic           load_ready,
    input  logic           start,
    input  logic [GW-1:0]  gens,
    input  logic           wrap,
    output logic           busy,
    output logic           done,
    output logic [X*Y-1:0] board,
    output logic [15:0]    gen_count,
    output state_t         dbg_state
);

    localparam int N  = X * Y;
    localparam int KW = $clog2(N);
    localparam int XW = $clog2(X);
    localparam int YW = $clog2(Y);

    // With cell k sitting at the top bit, linear offsets become fixed tap positions
    localparam int T_C  = N - 1;
    localparam int T_L  = N - 2;
    localparam int T_R  = 0;
    localparam int T_U  = N - 1 - X;
    localparam int T_D  = X - 1;
    localparam int T_LU = N - 2 - X;
    localparam int T_RU = N - X;
    localparam int T_LD = X - 2;
    localparam int T_RD = X;

    state_t        state, state_nxt;
    logic [N-1:0]  nxt;
    logic [N-1:0]  window;
    logic [GW-1:0] remaining;
    logic          wrap_q;
    logic [KW-1:0] k;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          alive;

    assign cur_x = XW'(k % KW'(X));
    assign cur_y = YW'(k / KW'(X));

    life_cell_rule #(.X(X), .Y(Y)) u_rule (
        .c     (window[T_C]),
        .l     (window[T_L]),
        .r     (window[T_R]),
        .u     (window[T_U]),
        .d     (window[T_D]),
        .lu    (window[T_LU]),
        .ru    (window[T_RU]),
        .ld    (window[T_LD]),
        .rd    (window[T_RD]),
        .x     (cur_x),
        .y     (cur_y),
        .wrap  (wrap_q),
        .alive (alive)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!load_valid && start) state_nxt = (gens == '0) ? DONE : PREP;
            end
            PREP:    state_nxt = SCAN;
            SCAN:    if (k == KW'(N - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = (remaining == GW'(1)) ? DONE : PREP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board     <= '0;
            nxt       <= '0;
            window    <= '0;
            gen_count <= '0;
            remaining <= '0;
            wrap_q    <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        board     <= load_data;
                        gen_count <= '0;
                    end else if (start && gens != '0) begin
                        wrap_q    <= wrap;
                        remaining <= gens;
                    end
                end
                PREP: begin
                    window <= {board[0], board[N-1:1]};
                    nxt    <= '0;
                    k      <= '0;
                end
                SCAN: begin
                    nxt[k] <= alive;
                    window <= {window[0], window[N-1:1]};
                    k      <= (k == KW'(N - 1)) ? '0 : k + 1'b1;
                end
                COMMIT: begin
                    board     <= nxt;
                    gen_count <= gen_count + 16'd1;
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: directed scenarios plus randomized boards, checked
// by a scoreboard against a 2-D reference model of the Life rule.
module tb_life_gen_engine;

  localparam int X  = 8;
  localparam int Y  = 8;
  localparam int GW = 8;
  localparam int N  = X * Y;
  localparam int W  = N + 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic [N-1:0]      load_data;
  logic              load_ready;
  logic              start;
  logic [GW-1:0]     gens;
  logic              wrap;
  logic              busy;
  logic              done;
  logic [N-1:0]      board;
  logic [15:0]       gen_count;
  life_pkg::state_t  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [N-1:0] mdl_board;
  logic [15:0]  mdl_gen;
  logic [W-1:0] mon_e;
  int           mon_c;

  life_gen_engine #(.X(X), .Y(Y), .GW(GW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .gens       (gens),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done),
    .board      (board),
    .gen_count  (gen_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: one Life generation over a 2-D board
  function automatic logic [N-1:0] life_step(input logic [N-1:0] b, input bit w);
    logic [N-1:0] r;
    r = '0;
    for (int y = 0; y < Y; y++) begin
      for (int x = 0; x < X; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            if (w) n += int'(b[((y * X + x) + dy * X + dx + N) % N]);
            else if (x + dx >= 0 && x + dx < X && y + dy >= 0 && y + dy < Y)
              n += int'(b[(y + dy) * X + x + dx]);
          end
        end
        r[y * X + x] = (n == 3) || (b[y * X + x] && n == 2);
      end
    end
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done pulsed with nothing expected (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("done_board", W'(board), W'(mon_e[W-1:16]));
        check("done_gen_count", W'(gen_count), W'(mon_e[15:0]));
        check("done_latency_cycle", W'(cyc), W'(mon_c));
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic do_load(input logic [N-1:0] d);
    load_data  = d;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    mdl_board  = d;
    mdl_gen    = '0;
    check("load_board", W'(board), W'(d));
    check("load_gen_count", W'(gen_count), '0);
  endtask

  task automatic run(input int g, input bit w, input bit use_ref,
                     input logic [N-1:0] ref_board, input bit disturb);
    logic [N-1:0] b;
    logic [N-1:0] pre;
    pre = mdl_board;
    b   = mdl_board;
    for (int i = 0; i < g; i++) b = life_step(b, w);
    if (use_ref) b = ref_board;
    mdl_board = b;
    mdl_gen   = mdl_gen + 16'(g);
    exp_q.push_back({b, mdl_gen});
    exp_cyc_q.push_back(cyc + g * (N + 2) + 1);
    gens  = GW'(g);
    wrap  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wrap  = 1'($urandom_range(0, 1));
    gens  = GW'($urandom);
    if (g == 0) begin
      check("zero_gens_busy_high", W'(busy), W'(1));
      @(negedge clk);
      check("zero_gens_busy_low", W'(busy), '0);
    end
    if (disturb && g > 0) begin
      repeat (10) @(negedge clk);
      load_data  = ~pre;
      load_valid = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      check("scan_load_ready", W'(load_ready), '0);
      check("scan_board_hold", W'(board), W'(pre));
      load_valid = 1'b0;
      start      = 1'b0;
      repeat (5) @(negedge clk);
      check("scan_board_hold_late", W'(board), W'(pre));
    end
    for (int i = 0; i < g * (N + 2) + 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("run_complete", W'(exp_q.size()), '0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("idle_after_run", W'({load_ready, busy}), W'(2'b10));
  endtask

  initial begin
    logic [N-1:0] d;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    gens       = '0;
    wrap       = 1'b0;
    mdl_board  = '0;
    mdl_gen    = '0;
    repeat (3) @(negedge clk);
    check("reset_board", W'(board), '0);
    check("reset_gen_count", W'(gen_count), '0);
    check("reset_busy_done", W'({busy, done}), '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", W'({load_ready, busy}), W'(2'b10));

    // directed scenarios
    do_load(64'h0000_0000_0000_0E00);
    run(1, 1'b0, 1'b1, 64'h0000_0000_0004_0404, 1'b0);
    do_load(64'h303);
    run(5, 1'b0, 1'b1, 64'h303, 1'b0);
    do_load(64'h7);
    run(1, 1'b0, 1'b1, 64'h202, 1'b0);
    do_load(64'h7);
    run(1, 1'b1, 1'b1, 64'h0200_0000_0000_0202, 1'b0);
    run(0, 1'b0, 1'b0, '0, 1'b0);
    do_load(64'h0000_0000_0000_0E00);
    run(2, 1'b0, 1'b0, '0, 1'b1);

    // load and start together: the load wins, no run begins
    d          = {$urandom, $urandom};
    load_data  = d;
    load_valid = 1'b1;
    start      = 1'b1;
    gens       = 8'd3;
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b0;
    mdl_board  = d;
    mdl_gen    = '0;
    check("load_wins_busy", W'(busy), '0);
    check("load_wins_board", W'(board), W'(d));
    repeat (5) @(negedge clk);

    // reset in the middle of SCAN at k=30
    start = 1'b1;
    gens  = 8'd3;
    wrap  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_board", W'(board), '0);
    check("midrun_reset_gen_count", W'(gen_count), '0);
    check("midrun_reset_busy", W'(busy), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_post_reset_ready", W'({load_ready, busy}), W'(2'b10));
    mdl_board = '0;
    mdl_gen   = '0;
    repeat (100) @(negedge clk);
    check("midrun_board_stays_zero", W'(board), '0);

    // randomized boards, generation counts and wrap modes
    for (int it = 0; it < 10; it++) begin
      if (it == 0 || $urandom_range(0, 2) != 0) begin
        d = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) d = d & {$urandom, $urandom};
        do_load(d);
      end
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, '0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
